// File: rtl/pbvi_pkg.sv
// Shared types and defaults for the PBVI backup scheduler and its step blocks.
package pbvi_pkg;

    localparam int N_BELIEF_DEF = 16;
    localparam int N_ACTION_DEF = 3;
    localparam int N_OBS_DEF    = 2;

    localparam int BELIEF_W = 4;
    localparam int ACTION_W = 2;
    localparam int OBS_W    = 1;
    localparam int IDX_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    typedef struct packed {
        logic [BELIEF_W-1:0] belief;
        logic [ACTION_W-1:0] action;
        logic [OBS_W-1:0]    obs;
    } coord_t;

    function automatic logic is_busy(state_e s);
        return (s == ST_ISSUE) || (s == ST_WAIT) || (s == ST_NEXT);
    endfunction

endpackage

// File: rtl/pbvi_backup_sched_if.sv
// Job/response channel between the backup scheduler and the dot-product/argmax engine.
interface pbvi_backup_sched_if;
    import pbvi_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [BELIEF_W-1:0] cmd_belief;
    logic [ACTION_W-1:0] cmd_action;
    logic [OBS_W-1:0]    cmd_obs;
    logic                rsp_valid;
    logic [IDX_W-1:0]    rsp_idx;

    modport master (
        output cmd_valid, cmd_belief, cmd_action, cmd_obs,
        input  cmd_ready, rsp_valid, rsp_idx
    );

    modport slave (
        input  cmd_valid, cmd_belief, cmd_action, cmd_obs,
        output cmd_ready, rsp_valid, rsp_idx
    );

endinterface

// File: rtl/pbvi_idx_table.sv
// Winning alpha-vector index per (belief, action, obs): one sync write, one comb read.
module pbvi_idx_table
    import pbvi_pkg::*;
#(
    parameter int N_BELIEF = N_BELIEF_DEF,
    parameter int N_ACTION = N_ACTION_DEF,
    parameter int N_OBS    = N_OBS_DEF
) (
    input  logic             clk,
    input  logic             we,
    input  coord_t           wr_addr,
    input  logic [IDX_W-1:0] wr_data,
    input  coord_t           rd_addr,
    output logic [IDX_W-1:0] rd_data
);

    localparam int DEPTH = N_BELIEF * N_ACTION * N_OBS;
    localparam int LW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [LW-1:0]    wr_lin;
    logic [LW-1:0]    rd_lin;

    function automatic logic [LW-1:0] lin(coord_t c);
        return LW'((int'(c.belief) * N_ACTION + int'(c.action)) * N_OBS + int'(c.obs));
    endfunction

    always_comb begin
        wr_lin  = lin(wr_addr);
        rd_lin  = lin(rd_addr);
        rd_data = '0;
        if ({1'b0, rd_lin} < (LW + 1)'(DEPTH)) begin
            rd_data = mem_q[rd_lin];
        end
    end

    // NOTE: the table has no reset; its contents are only meaningful after a completed sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_lin] <= wr_data;
        end
    end

endmodule

// File: rtl/pbvi_backup_sched.sv
// Sweeps every (belief, action, obs) job through the shared engine and stores each result.
module pbvi_backup_sched
    import pbvi_pkg::*;
#(
    parameter int N_BELIEF = N_BELIEF_DEF,
    parameter int N_ACTION = N_ACTION_DEF,
    parameter int N_OBS    = N_OBS_DEF,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                err,
    pbvi_backup_sched_if.master eng,
    input  logic [BELIEF_W-1:0] rd_belief,
    input  logic [ACTION_W-1:0] rd_action,
    input  logic [OBS_W-1:0]    rd_obs,
    output logic [IDX_W-1:0]    rd_idx
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e        state_q, state_d;
    coord_t        pos_q, pos_d;
    coord_t        pos_nxt;
    logic          pos_last;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;
    logic          tbl_we;
    logic          tbl_we_gated;
    coord_t        rd_c;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        pos_last = (int'(pos_q.belief) == N_BELIEF - 1) &&
                   (int'(pos_q.action) == N_ACTION - 1) &&
                   (int'(pos_q.obs)    == N_OBS - 1);
        pos_nxt = pos_q;
        if (int'(pos_q.obs) == N_OBS - 1) begin
            pos_nxt.obs = '0;
            if (int'(pos_q.action) == N_ACTION - 1) begin
                pos_nxt.action = '0;
                if (int'(pos_q.belief) == N_BELIEF - 1) pos_nxt.belief = '0;
                else                                     pos_nxt.belief = pos_q.belief + BELIEF_W'(1);
            end else begin
                pos_nxt.action = pos_q.action + ACTION_W'(1);
            end
        end else begin
            pos_nxt.obs = pos_q.obs + OBS_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        tbl_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pos_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (eng.cmd_ready) begin
                    wcnt_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response on the expiring cycle still wins over the timeout.
                if (eng.rsp_valid) begin
                    tbl_we  = 1'b1;
                    state_d = ST_NEXT;
                end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            ST_NEXT: begin
                if (pos_last) begin
                    state_d = ST_DONE;
                end else begin
                    pos_d   = pos_nxt;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && is_busy(state_q)) begin
            state_d = ST_IDLE;
            pos_d   = pos_q;
            wcnt_d  = wcnt_q;
            tbl_we  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    assign busy           = is_busy(state_q);
    assign done           = (state_q == ST_DONE);
    assign err            = err_q;
    assign eng.cmd_valid  = (state_q == ST_ISSUE);
    assign eng.cmd_belief = pos_q.belief;
    assign eng.cmd_action = pos_q.action;
    assign eng.cmd_obs    = pos_q.obs;

    assign tbl_we_gated = tbl_we && !rst;
    assign rd_c         = {rd_belief, rd_action, rd_obs};

    pbvi_idx_table #(
        .N_BELIEF (N_BELIEF),
        .N_ACTION (N_ACTION),
        .N_OBS    (N_OBS)
    ) u_table (
        .clk     (clk),
        .we      (tbl_we_gated),
        .wr_addr (pos_q),
        .wr_data (eng.rsp_idx),
        .rd_addr (rd_c),
        .rd_data (rd_idx)
    );

endmodule

// File: tb/tb_pbvi_backup_sched.sv
// Directed bench for pbvi_backup_sched: engine model, latency checks and table readback.
module tb_pbvi_backup_sched;
    import pbvi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] rd_belief;
    logic [1:0] rd_action;
    logic       rd_obs;
    logic [3:0] rd_idx;

    pbvi_backup_sched_if eng_if();

    pbvi_backup_sched #(
        .N_BELIEF (16),
        .N_ACTION (3),
        .N_OBS    (2),
        .TIMEOUT  (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .eng       (eng_if),
        .rd_belief (rd_belief),
        .rd_action (rd_action),
        .rd_obs    (rd_obs),
        .rd_idx    (rd_idx)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    logic [3:0] model_tab [16][3][2];

    // Engine configuration, written only by the main sequence.
    logic [3:0] eng_key;
    coord_t     stall_at;
    int         stall_n;
    int         stall_req;
    logic       drop_en;
    coord_t     drop_at;
    logic       dly_en;
    coord_t     dly_at;
    int         dly_n;
    int         stray_req;

    // Engine state, written only by the engine process.
    int         stall_seen;
    int         stall_left;
    logic       stall_active;
    int         stall_bad;
    int         pend_cnt;
    logic [3:0] p_idx;
    int         n_acc;
    int         stray_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine: accepts on negedge-decided ready, answers after 1 + optional delay cycles.
    initial begin
        coord_t cur;
        eng_if.cmd_ready = 1'b1;
        eng_if.rsp_valid = 1'b0;
        eng_if.rsp_idx   = 4'h0;
        stall_seen = 0; stall_left = 0; stall_active = 1'b0; stall_bad = 0;
        pend_cnt = 0; p_idx = 4'h0; n_acc = 0; stray_ack = 0;
        forever begin
            @(negedge clk);
            eng_if.rsp_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    eng_if.rsp_valid = 1'b1;
                    eng_if.rsp_idx   = p_idx;
                end
            end else if (stray_req != stray_ack) begin
                eng_if.rsp_valid = 1'b1;
                eng_if.rsp_idx   = 4'hF;
                stray_ack        = stray_req;
            end
            if (stall_req != stall_seen) begin
                stall_left = stall_n;
                stall_seen = stall_req;
            end
            cur = {eng_if.cmd_belief, eng_if.cmd_action, eng_if.cmd_obs};
            eng_if.cmd_ready = 1'b1;
            if (eng_if.cmd_valid && stall_left > 0 && (stall_active || cur == stall_at)) begin
                stall_active = 1'b1;
                if (cur != stall_at) stall_bad++;
                eng_if.cmd_ready = 1'b0;
                stall_left--;
            end else begin
                stall_active = 1'b0;
                if (eng_if.cmd_valid) begin
                    n_acc++;
                    p_idx = cur.belief ^ {2'b00, cur.action} ^ {3'b000, cur.obs} ^ eng_key;
                    if (drop_en && cur == drop_at)     pend_cnt = 0;
                    else if (dly_en && cur == dly_at)  pend_cnt = 1 + dly_n;
                    else                               pend_cnt = 1;
                end
            end
        end
    end

    task automatic model_fill(input logic [3:0] key, input int first, input int last);
        for (int j = first; j <= last; j++) begin
            int b;
            int a;
            int o;
            b = j / 6;
            a = (j / 2) % 3;
            o = j % 2;
            model_tab[b][a][o] = 4'(b) ^ 4'(a) ^ 4'(o) ^ key;
        end
    endtask

    task automatic readback_all(input string tag);
        for (int b = 0; b < 16; b++) begin
            for (int a = 0; a < 3; a++) begin
                for (int o = 0; o < 2; o++) begin
                    @(negedge clk);
                    rd_belief = 4'(b);
                    rd_action = 2'(a);
                    rd_obs    = 1'(o);
                    #1;
                    check($sformatf("%s[%0d][%0d][%0d]", tag, b, a, o), 32'(rd_idx), 32'(model_tab[b][a][o]));
                end
            end
        end
    endtask

    // Pulses start, then counts cycles until done (n=1 is the first ISSUE cycle).
    task automatic run_sweep(input logic [3:0] key, input int exp_lat, input bit extra_starts, input string tag);
        int  n;
        int  acc0;
        bit  seen;
        eng_key = key;
        acc0    = n_acc;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        check({tag, " busy at first cycle"}, 32'(busy), 32'd1);
        check({tag, " err cleared by start"}, 32'(err), 32'd0);
        check({tag, " first cmd"}, {28'd0, eng_if.cmd_valid, eng_if.cmd_belief == 4'd0,
                                    eng_if.cmd_action == 2'd0, eng_if.cmd_obs == 1'b0}, 32'hF);
        seen = 1'b0;
        while (n < 2000) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = extra_starts && (n == 50 || n == 151 || n == 288);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " jobs accepted"}, 32'(n_acc - acc0), 32'd96);
        check({tag, " err at done"}, 32'(err), 32'd0);
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " idle after done"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, " no rerun"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  n;
        bit  seen_err;
        bit  seen_done;
        bit  found;
        n_checks = 0; n_errors = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        rd_belief = 4'd0; rd_action = 2'd0; rd_obs = 1'b0;
        eng_key = 4'h0; stall_at = '0; stall_n = 0; stall_req = 0;
        drop_en = 1'b0; drop_at = '0; dly_en = 1'b0; dly_at = '0; dly_n = 0;
        stray_req = 0;

        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset cmd_valid", 32'(eng_if.cmd_valid), 32'd0);
        rst = 1'b0;

        // Zero-wait engine: 96 jobs x 3 cycles, DONE on cycle 289.
        run_sweep(4'h0, 289, 1'b0, "sweep0");
        model_fill(4'h0, 0, 95);
        readback_all("rb0");

        // Ready held low 5 cycles on job (0,0,1).
        stall_at = {4'd0, 2'd0, 1'b1};
        stall_n  = 5;
        stall_req++;
        run_sweep(4'h5, 294, 1'b0, "stall");
        check("stall coords stable", 32'(stall_bad), 32'd0);
        check("stall consumed", 32'(stall_left), 32'd0);
        model_fill(4'h5, 0, 95);
        readback_all("rb_stall");

        // Response on the 64th WAIT cycle of job (2,1,0) counts as a response.
        dly_en = 1'b1;
        dly_at = {4'd2, 2'd1, 1'b0};
        dly_n  = 63;
        run_sweep(4'hB, 352, 1'b0, "late_rsp");
        dly_en = 1'b0;
        model_fill(4'hB, 0, 95);

        // No response for job (3,2,0): ERR after 64 WAIT cycles, job 22 WAIT starts at n=68.
        drop_en = 1'b1;
        drop_at = {4'd3, 2'd2, 1'b0};
        eng_key = 4'hA;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; seen_err = 1'b0; seen_done = 1'b0;
        while (n < 500) begin
            if (done) seen_done = 1'b1;
            if (err) begin
                seen_err = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check("timeout err seen", 32'(seen_err), 32'd1);
        check("timeout cycle", 32'(n), 32'd132);
        check("timeout no done", 32'(seen_done), 32'd0);
        check("timeout not busy in ERR", 32'(busy), 32'd0);
        @(negedge clk);
        check("err sticky in IDLE", 32'(err), 32'd1);
        check("no done after ERR", 32'(done), 32'd0);
        check("idle after ERR", 32'(busy), 32'd0);
        drop_en = 1'b0;
        model_fill(4'hA, 0, 21);
        readback_all("rb_timeout");

        // Abort on the WAIT cycle of job (7,1,1) while the engine answers.
        eng_key = 4'h3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort run err cleared", 32'(err), 32'd0);
        n = 1; found = 1'b0;
        while (n < 400) begin
            if (eng_if.cmd_valid && eng_if.cmd_belief == 4'd7 && eng_if.cmd_action == 2'd1 && eng_if.cmd_obs == 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check("abort job reached", 32'(found), 32'd1);
        check("abort job issue cycle", 32'(n), 32'd136);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort idle", 32'(busy), 32'd0);
        check("abort no done", 32'(done), 32'd0);
        check("abort cmd_valid low", 32'(eng_if.cmd_valid), 32'd0);
        model_fill(4'h3, 0, 44);

        // Stray response while IDLE must not touch the table.
        stray_req++;
        repeat (3) @(negedge clk);
        check("stray idle", 32'(busy), 32'd0);
        readback_all("rb_abort");

        // Full sweep after abort, with start pulses while busy.
        run_sweep(4'h6, 289, 1'b1, "post_abort");
        model_fill(4'h6, 0, 95);
        readback_all("rb_post");

        // Reset mid-WAIT (n=20 is a WAIT cycle), then reset overriding start.
        eng_key = 4'h9;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre-rst busy in WAIT", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst cmd_valid", 32'(eng_if.cmd_valid), 32'd0);
        start = 1'b1;
        @(negedge clk);
        check("rst overrides start", 32'(busy), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle after rst", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
